muldiv_iter: RTL
================

# muldiv_iter

Iterative multiply/divide unit for the mips789 execute stage. It consumes the two register-file read operands (rs, rt) and the decoded mult/div control, and computes MULT, MULTU, DIV and DIVU over 32 iteration cycles. Results go into architectural HI/LO registers, which also take MTHI/MTLO writes. It drives `busy` to the pipeline pause logic, so a later MFHI/MFLO or mult/div stalls until the result is committed.

## Interface
Parameters: none (32-bit datapath fixed).

Ports:
- `clock`  in  1  — single clock; all state on rising edge.
- `rst`  in  1  — asynchronous, active-high reset.
- `pause`  in  1  — pipeline pause; freezes the unit and blocks command acceptance.
- `ctl`  in  3  — command: 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 NOP (reserved).
- `op_s`  in  32  — rs operand (multiplicand / dividend / MTHI-MTLO data).
- `op_t`  in  32  — rt operand (multiplier / divisor).
- `hi`  out  32  — HI register (registered).
- `lo`  out  32  — LO register (registered).
- `busy`  out  1  — high while state ≠ IDLE (decoded from state register, no input path).

## Operation
- States: IDLE, RUN, FIX.
- IDLE, `pause`=0:
  - `ctl`∈{1..4}: latch |op_s|, |op_t| (unsigned for 2/4, two's-complement magnitude for 1/3), latch result sign, latch raw op_s, latch op_t==0 flag; count←0; go to RUN.
  - `ctl`=5: hi←op_s. `ctl`=6: lo←op_s. Stay IDLE.
  - Any other value: no effect.
- RUN: one radix-2 step per unpaused cycle.
  - Multiply: shift-add into a 64-bit accumulator.
  - Divide: restoring shift-subtract; 64-bit {rem, quot} register.
  - count increments per step; after step 32 (count==31 at the edge) go to FIX.
- FIX, one cycle, commits on exit to IDLE:
  - Multiply: {hi,lo} ← product, two's-complement negated if sign flag is set.
  - Divide: lo ← quotient, negated if the operand signs differ (signed only); hi ← remainder, negated if the dividend was negative (signed only).
- Magnitude of 0x80000000 is 0x80000000 as unsigned and is handled naturally.
- DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- Divide by zero (latched flag), both DIV and DIVU: hi←raw op_s, lo←32'hFFFFFFFF. Full 33-cycle latency still applies.
- Commands (including MTHI/MTLO) presented while `busy`=1 are ignored. The hazard logic guarantees they are held/stalled.
- `pause`=1 in any state: state, count, datapath and hi/lo hold. A command on `ctl` is not accepted.
- `rst`: immediately state←IDLE, count←0, hi←0, lo←0, `busy`←0. An in-flight operation is discarded and hi/lo are not updated.

## Timing
- Reset values: hi=0, lo=0, busy=0.
- Start edge E0 (IDLE, ctl∈1..4, pause=0): busy rises after E0.
- RUN occupies edges E1..E32. FIX commits hi/lo at E33. busy falls after E33.
- busy is high for exactly 33 cycles without pause. Each paused cycle adds one.
- hi/lo hold their old values until E33. There are no partial updates.
- MTHI/MTLO: hi/lo visible the cycle after the accepting edge; busy stays 0.
- A new command may be accepted on the edge right after busy falls.

## Test plan
- Reset, then MULT op_s=0xFFFFFFFD (−3), op_t=5 → busy high 33 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- MULTU 0xFFFFFFFF×0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. Back-to-back DIVU 100/7 accepted the cycle after busy falls → lo=14, hi=2.
- DIV −7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU 0x1234/0 → hi=0x00001234, lo=0xFFFFFFFF after 33 cycles.
- MTHI 0xA5A5A5A5 → hi updated next cycle, busy=0.
- MULT 6×7 with `pause` held for 5 cycles mid-RUN → busy high 38 cycles; result hi=0, lo=42.
- MTLO during busy → ignored; lo keeps its old value until the FIX commit.
- MULT started, `rst` asserted at cycle 10 → busy=0, hi=lo=0 immediately; no later commit occurs.

Source files
------------

// File: rtl/muldiv_iter_if.sv
// muldiv_iter_if: command, operand and HI/LO result bundle of the iterative multiply/divide unit.
// Revision 1.0
`default_nettype none

interface muldiv_iter_if;
  logic        pause;
  logic [2:0]  ctl;
  logic [31:0] op_s;
  logic [31:0] op_t;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;

  modport master (
    output pause, ctl, op_s, op_t,
    input  hi, lo, busy
  );

  modport slave (
    input  pause, ctl, op_s, op_t,
    output hi, lo, busy
  );
endinterface

`default_nettype wire

// File: rtl/muldiv_iter.sv
// muldiv_iter: 32-cycle radix-2 MULT/MULTU/DIV/DIVU unit with architectural HI/LO and MTHI/MTLO.
// Revision 1.0
`default_nettype none

module muldiv_iter (
  input  logic          clock,
  input  logic          rst,
  muldiv_iter_if.slave  bus
);

  localparam logic [2:0] C_CTL_MULT  = 3'd1;
  localparam logic [2:0] C_CTL_MULTU = 3'd2;
  localparam logic [2:0] C_CTL_DIV   = 3'd3;
  localparam logic [2:0] C_CTL_DIVU  = 3'd4;
  localparam logic [2:0] C_CTL_MTHI  = 3'd5;
  localparam logic [2:0] C_CTL_MTLO  = 3'd6;
  localparam logic [4:0] C_LAST_STEP = 5'd31;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t      r_state;
  logic [4:0]  r_count;
  logic        r_is_div;
  logic        r_neg_res;
  logic        r_neg_rem;
  logic        r_div0;
  logic [31:0] r_raw_s;
  logic [31:0] r_a;
  logic [63:0] r_acc;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic        w_cmd_md;
  logic        w_signed;
  logic        w_cmd_div;
  logic [31:0] w_abs_s;
  logic [31:0] w_abs_t;
  logic [32:0] w_madd;
  logic [63:0] w_mul_next;
  logic [32:0] w_rem_sh;
  logic        w_div_ge;
  logic [31:0] w_dsub;
  logic [63:0] w_div_next;
  logic [63:0] w_prod_neg;
  logic [31:0] w_quot;
  logic [31:0] w_rem;

  assign w_cmd_md  = (bus.ctl == C_CTL_MULT) || (bus.ctl == C_CTL_MULTU) ||
                     (bus.ctl == C_CTL_DIV)  || (bus.ctl == C_CTL_DIVU);
  assign w_signed  = (bus.ctl == C_CTL_MULT) || (bus.ctl == C_CTL_DIV);
  assign w_cmd_div = (bus.ctl == C_CTL_DIV)  || (bus.ctl == C_CTL_DIVU);
  assign w_abs_s   = (w_signed && bus.op_s[31]) ? (32'd0 - bus.op_s) : bus.op_s;
  assign w_abs_t   = (w_signed && bus.op_t[31]) ? (32'd0 - bus.op_t) : bus.op_t;

  // Multiply: r_acc = {partial product, remaining multiplier bits}; r_a holds the multiplicand.
  assign w_madd     = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_a} : 33'd0);
  assign w_mul_next = {w_madd, r_acc[31:1]};

  // Divide: r_acc = {remainder, dividend/quotient}; r_a holds the divisor.
  // The true difference is below 2^32 whenever it is taken, so 32 bits suffice.
  assign w_rem_sh   = r_acc[63:31];
  assign w_div_ge   = (w_rem_sh >= {1'b0, r_a});
  assign w_dsub     = w_rem_sh[31:0] - r_a;
  assign w_div_next = w_div_ge ? {w_dsub, r_acc[30:0], 1'b1} : {r_acc[62:0], 1'b0};

  assign w_prod_neg = 64'd0 - r_acc;
  assign w_quot     = r_acc[31:0];
  assign w_rem      = r_acc[63:32];

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_count   <= 5'd0;
      r_is_div  <= 1'b0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_div0    <= 1'b0;
      r_raw_s   <= 32'd0;
      r_a       <= 32'd0;
      r_acc     <= 64'd0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
    end else if (!bus.pause) begin
      case (r_state)
        S_IDLE: begin
          if (w_cmd_md) begin
            r_is_div  <= w_cmd_div;
            r_neg_res <= w_signed && (bus.op_s[31] ^ bus.op_t[31]);
            r_neg_rem <= w_signed && bus.op_s[31];
            r_div0    <= (bus.op_t == 32'd0);
            r_raw_s   <= bus.op_s;
            r_count   <= 5'd0;
            if (w_cmd_div) begin
              r_a   <= w_abs_t;
              r_acc <= {32'd0, w_abs_s};
            end else begin
              r_a   <= w_abs_s;
              r_acc <= {32'd0, w_abs_t};
            end
            r_state <= S_RUN;
          end else if (bus.ctl == C_CTL_MTHI) begin
            r_hi <= bus.op_s;
          end else if (bus.ctl == C_CTL_MTLO) begin
            r_lo <= bus.op_s;
          end
        end

        S_RUN: begin
          r_acc   <= r_is_div ? w_div_next : w_mul_next;
          r_count <= r_count + 5'd1;
          if (r_count == C_LAST_STEP) begin
            r_state <= S_FIX;
          end
        end

        S_FIX: begin
          if (!r_is_div) begin
            {r_hi, r_lo} <= r_neg_res ? w_prod_neg : r_acc;
          end else if (r_div0) begin
            r_hi <= r_raw_s;
            r_lo <= 32'hFFFF_FFFF;
          end else begin
            r_lo <= r_neg_res ? (32'd0 - w_quot) : w_quot;
            r_hi <= r_neg_rem ? (32'd0 - w_rem) : w_rem;
          end
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy = (r_state != S_IDLE);
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;

endmodule

`default_nettype wire
